// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode/funct encodings, ALU operation codes
// and the decoded control bundle carried down the pipeline.
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1011;
    localparam logic [3:0] ALU_SRA = 4'b1100;
    localparam logic [3:0] ALU_SRL = 4'b1101;
    localparam logic [3:0] ALU_SLL = 4'b1110;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       reg_dst;
        logic       jump;
        logic [3:0] alu_control;
    } ctrl_t;

    // All-zero control: a bubble never writes a register or memory.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard check between the load in execute and the
// instruction in decode. Register $0 never creates a dependency.
module load_use_detector
    import mips_pkg::*;
(
    input  logic       validE,
    input  logic       MemtoRegE,
    input  logic [4:0] RtE,
    input  logic       validD,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    output logic       hazard
);

    logic rt_nonzero;
    logic src_match;

    assign rt_nonzero = (RtE != 5'd0);
    assign src_match  = (RtE == RsD) || (RtE == RtD);
    assign hazard     = validE && MemtoRegE && rt_nonzero && validD && src_match;

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use bubble insertion, flush
// squashing and a saturating count of bubbles that displaced real work.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int BUBBLE_CNT_W = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    validD,
    input  logic                    RegWriteD,
    input  logic                    MemtoRegD,
    input  logic                    MemWriteD,
    input  logic                    BranchD,
    input  logic                    RegDstD,
    input  logic                    JumpD,
    input  logic [3:0]              ALUControlD,
    input  logic [31:0]             regA,
    input  logic [31:0]             regB,
    input  logic [31:0]             extend_immediate,
    input  logic [4:0]              RsD,
    input  logic [4:0]              RtD,
    input  logic [4:0]              RdD,
    input  logic [31:0]             PCPlus4D,
    input  logic                    flushE,
    output logic                    RegWriteE,
    output logic                    MemtoRegE,
    output logic                    MemWriteE,
    output logic                    BranchE,
    output logic                    RegDstE,
    output logic                    JumpE,
    output logic [3:0]              ALUControlE,
    output logic [31:0]             SrcAE,
    output logic [31:0]             SrcBE,
    output logic [31:0]             ImmE,
    output logic [31:0]             PCPlus4E,
    output logic [4:0]              RsE,
    output logic [4:0]              RtE,
    output logic [4:0]              RdE,
    output logic                    validE,
    output logic                    stallD,
    output logic [BUBBLE_CNT_W-1:0] bubble_count
);

    ctrl_t                   ctrl_q, ctrl_d;
    logic [31:0]             src_a_q, src_a_d;
    logic [31:0]             src_b_q, src_b_d;
    logic [31:0]             imm_q, imm_d;
    logic [31:0]             pc_plus4_q, pc_plus4_d;
    logic [4:0]              rs_q, rs_d;
    logic [4:0]              rt_q, rt_d;
    logic [4:0]              rd_q, rd_d;
    logic                    valid_q, valid_d;
    logic [BUBBLE_CNT_W-1:0] cnt_q, cnt_d;

    logic hazard;
    logic bubble;
    ctrl_t ctrl_in;

    load_use_detector u_load_use_detector (
        .validE    (valid_q),
        .MemtoRegE (ctrl_q.mem_to_reg),
        .RtE       (rt_q),
        .validD    (validD),
        .RsD       (RsD),
        .RtD       (RtD),
        .hazard    (hazard)
    );

    assign ctrl_in = '{
        reg_write:   RegWriteD,
        mem_to_reg:  MemtoRegD,
        mem_write:   MemWriteD,
        branch:      BranchD,
        reg_dst:     RegDstD,
        jump:        JumpD,
        alu_control: ALUControlD
    };

    // A flush coinciding with a hazard still loads a single bubble.
    assign bubble = flushE || hazard;

    always_comb begin
        ctrl_d     = ctrl_in;
        src_a_d    = regA;
        src_b_d    = regB;
        imm_d      = extend_immediate;
        pc_plus4_d = PCPlus4D;
        rs_d       = RsD;
        rt_d       = RtD;
        rd_d       = RdD;
        valid_d    = validD;
        cnt_d      = cnt_q;

        if (bubble) begin
            ctrl_d     = CTRL_BUBBLE;
            src_a_d    = '0;
            src_b_d    = '0;
            imm_d      = '0;
            pc_plus4_d = '0;
            rs_d       = '0;
            rt_d       = '0;
            rd_d       = '0;
            valid_d    = 1'b0;
        end

        // Only bubbles that displace a real decode instruction are counted.
        if (bubble && validD && (cnt_q != {BUBBLE_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q     <= CTRL_BUBBLE;
            src_a_q    <= '0;
            src_b_q    <= '0;
            imm_q      <= '0;
            pc_plus4_q <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            imm_q      <= imm_d;
            pc_plus4_q <= pc_plus4_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign RegWriteE    = ctrl_q.reg_write;
    assign MemtoRegE    = ctrl_q.mem_to_reg;
    assign MemWriteE    = ctrl_q.mem_write;
    assign BranchE      = ctrl_q.branch;
    assign RegDstE      = ctrl_q.reg_dst;
    assign JumpE        = ctrl_q.jump;
    assign ALUControlE  = ctrl_q.alu_control;
    assign SrcAE        = src_a_q;
    assign SrcBE        = src_b_q;
    assign ImmE         = imm_q;
    assign PCPlus4E     = pc_plus4_q;
    assign RsE          = rs_q;
    assign RtE          = rt_q;
    assign RdE          = rd_q;
    assign validE       = valid_q;
    assign stallD       = hazard;
    assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a cycle-level
// behavioural model of the decode/execute register and its bubble counter.
module tb_id_ex_stage;

    logic        clock;
    logic        reset;
    logic        validD;
    logic        RegWriteD, MemtoRegD, MemWriteD, BranchD, RegDstD, JumpD;
    logic [3:0]  ALUControlD;
    logic [31:0] regA, regB, extend_immediate, PCPlus4D;
    logic [4:0]  RsD, RtD, RdD;
    logic        flushE;
    logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, RegDstE, JumpE;
    logic [3:0]  ALUControlE;
    logic [31:0] SrcAE, SrcBE, ImmE, PCPlus4E;
    logic [4:0]  RsE, RtE, RdE;
    logic        validE;
    logic        stallD;
    logic [15:0] bubble_count;

    id_ex_stage #(.BUBBLE_CNT_W(16)) dut (
        .clock            (clock),
        .reset            (reset),
        .validD           (validD),
        .RegWriteD        (RegWriteD),
        .MemtoRegD        (MemtoRegD),
        .MemWriteD        (MemWriteD),
        .BranchD          (BranchD),
        .RegDstD          (RegDstD),
        .JumpD            (JumpD),
        .ALUControlD      (ALUControlD),
        .regA             (regA),
        .regB             (regB),
        .extend_immediate (extend_immediate),
        .RsD              (RsD),
        .RtD              (RtD),
        .RdD              (RdD),
        .PCPlus4D         (PCPlus4D),
        .flushE           (flushE),
        .RegWriteE        (RegWriteE),
        .MemtoRegE        (MemtoRegE),
        .MemWriteE        (MemWriteE),
        .BranchE          (BranchE),
        .RegDstE          (RegDstE),
        .JumpE            (JumpE),
        .ALUControlE      (ALUControlE),
        .SrcAE            (SrcAE),
        .SrcBE            (SrcBE),
        .ImmE             (ImmE),
        .PCPlus4E         (PCPlus4E),
        .RsE              (RsE),
        .RtE              (RtE),
        .RdE              (RdE),
        .validE           (validE),
        .stallD           (stallD),
        .bubble_count     (bubble_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Reference model of what the execute stage holds.
    logic [9:0]   m_ctrl;
    logic [127:0] m_data;
    logic [14:0]  m_regs;
    logic         m_valid;
    int           m_cnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_ctrl  = '0;
        m_data  = '0;
        m_regs  = '0;
        m_valid = 1'b0;
    endtask

    function automatic logic model_hazard();
        logic is_load;
        logic [4:0] rt_e;
        is_load = m_ctrl[8];
        rt_e    = m_regs[9:5];
        return m_valid && is_load && (rt_e != 0) && validD && (rt_e == RsD || rt_e == RtD);
    endfunction

    task automatic clear_d();
        validD = 0; RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; BranchD = 0;
        RegDstD = 0; JumpD = 0; ALUControlD = 0; regA = 0; regB = 0;
        extend_immediate = 0; PCPlus4D = 0; RsD = 0; RtD = 0; RdD = 0; flushE = 0;
    endtask

    task automatic rand_d();
        validD = ($urandom_range(0, 7) != 0);
        RegWriteD = 1'($urandom); MemtoRegD = 1'($urandom); MemWriteD = 1'($urandom);
        BranchD = 1'($urandom); RegDstD = 1'($urandom); JumpD = 1'($urandom);
        ALUControlD = 4'($urandom);
        regA = $urandom; regB = $urandom; extend_immediate = $urandom; PCPlus4D = $urandom;
        RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3)); RdD = 5'($urandom);
        flushE = ($urandom_range(0, 7) == 0);
    endtask

    // One clock: check stallD before the edge, advance the model, check E after.
    task automatic step(input bit rst, input bit chk_stall, input bit chk_out);
        logic hz;
        reset = rst;
        #1;
        hz = model_hazard();
        if (chk_stall) chk("stallD", 128'(stallD), 128'(hz));
        @(posedge clock);
        if (rst) begin
            model_clear();
            m_cnt = 0;
        end else if (flushE || hz) begin
            model_clear();
            if (validD && m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
            m_ctrl  = {RegWriteD, MemtoRegD, MemWriteD, BranchD, RegDstD, JumpD, ALUControlD};
            m_data  = {regA, regB, extend_immediate, PCPlus4D};
            m_regs  = {RsD, RtD, RdD};
            m_valid = validD;
        end
        #1;
        if (chk_out) begin
            chk("ctrl", 128'({RegWriteE, MemtoRegE, MemWriteE, BranchE, RegDstE, JumpE, ALUControlE}), 128'(m_ctrl));
            chk("data", {SrcAE, SrcBE, ImmE, PCPlus4E}, m_data);
            chk("regs", 128'({RsE, RtE, RdE}), 128'(m_regs));
            chk("validE", 128'(validE), 128'(m_valid));
            chk("bubble_count", 128'(bubble_count), 128'(m_cnt));
        end
    endtask

    task automatic do_reset();
        clear_d();
        step(1, 1, 1);
    endtask

    task automatic put_load(input logic [4:0] rt);
        clear_d();
        validD = 1; MemtoRegD = 1; RegWriteD = 1; RsD = 5'd1; RtD = rt;
        ALUControlD = mips_pkg::ALU_ADD;
    endtask

    task automatic put_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        clear_d();
        validD = 1; RegWriteD = 1; RegDstD = 1; RsD = rs; RtD = rt; RdD = rd;
        ALUControlD = mips_pkg::ALU_ADD; regA = 32'd11; regB = 32'd22;
    endtask

    initial begin
        model_clear();
        m_cnt = 0;
        clear_d();
        reset = 1;
        #2;

        // Reset with random D inputs for two cycles.
        rand_d();
        step(1, 0, 1);
        rand_d();
        step(1, 1, 1);
        chk("reset_bubble_count", 128'(bubble_count), 128'(0));
        chk("reset_stallD", 128'(stallD), 128'(0));

        // Pass-through.
        clear_d();
        validD = 1; ALUControlD = 4'b0010; regA = 32'd5; regB = 32'd7; RdD = 5'd3; RegWriteD = 1;
        step(0, 1, 1);
        chk("pt_SrcAE", 128'(SrcAE), 128'(5));
        chk("pt_SrcBE", 128'(SrcBE), 128'(7));
        chk("pt_RdE", 128'(RdE), 128'(3));
        chk("pt_RegWriteE", 128'(RegWriteE), 128'(1));
        chk("pt_validE", 128'(validE), 128'(1));

        // Load-use: lw $8 then add using $8.
        do_reset();
        put_load(5'd8);
        step(0, 1, 1);
        put_add(5'd8, 5'd9, 5'd10);
        #1;
        chk("lu_stall_same_cycle", 128'(stallD), 128'(1));
        step(0, 1, 1);
        chk("lu_validE", 128'(validE), 128'(0));
        chk("lu_RegWriteE", 128'(RegWriteE), 128'(0));
        chk("lu_bubble_count", 128'(bubble_count), 128'(1));
        chk("lu_stall_released", 128'(stallD), 128'(0));
        step(0, 1, 1);
        chk("lu_add_RsE", 128'(RsE), 128'(8));
        chk("lu_add_validE", 128'(validE), 128'(1));

        // $0 load never stalls.
        do_reset();
        put_load(5'd0);
        step(0, 1, 1);
        put_add(5'd0, 5'd0, 5'd4);
        #1;
        chk("r0_stallD", 128'(stallD), 128'(0));
        step(0, 1, 1);
        chk("r0_validE", 128'(validE), 128'(1));
        chk("r0_bubble_count", 128'(bubble_count), 128'(0));

        // Flush coinciding with a hazard.
        do_reset();
        put_load(5'd5);
        step(0, 1, 1);
        put_add(5'd5, 5'd2, 5'd6);
        flushE = 1;
        #1;
        chk("fh_stallD", 128'(stallD), 128'(1));
        step(0, 1, 1);
        chk("fh_bubble_count", 128'(bubble_count), 128'(1));
        chk("fh_validE", 128'(validE), 128'(0));
        flushE = 0;
        step(0, 1, 1);
        chk("fh_retry_validE", 128'(validE), 128'(1));
        chk("fh_retry_count", 128'(bubble_count), 128'(1));

        // Back-to-back dependent loads: one bubble each.
        do_reset();
        put_load(5'd7);
        step(0, 1, 1);
        clear_d();
        validD = 1; MemtoRegD = 1; RegWriteD = 1; RsD = 5'd7; RtD = 5'd9;
        step(0, 1, 1);
        step(0, 1, 1);
        put_add(5'd9, 5'd0, 5'd1);
        step(0, 1, 1);
        step(0, 1, 1);
        chk("b2b_bubble_count", 128'(bubble_count), 128'(2));
        chk("b2b_validE", 128'(validE), 128'(1));

        // Reset in the middle of a stall adds no count.
        do_reset();
        put_load(5'd3);
        step(0, 1, 1);
        put_add(5'd3, 5'd3, 5'd2);
        step(1, 1, 1);
        chk("rms_bubble_count", 128'(bubble_count), 128'(0));
        chk("rms_validE", 128'(validE), 128'(0));

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_d();
            step(($urandom_range(0, 99) == 0), 1, 1);
        end

        // Saturation of the bubble counter.
        do_reset();
        clear_d();
        validD = 1; flushE = 1;
        for (int i = 0; i < 65534; i++) step(0, 0, 0);
        chk("sat_preload", 128'(bubble_count), 128'(16'hFFFE));
        for (int i = 0; i < 3; i++) step(0, 1, 1);
        chk("sat_final", 128'(bubble_count), 128'(16'hFFFF));

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the 5-stage MIPS core with built-in load-use hazard detection. It sits directly downstream of `control_unit`. It captures that block's decoded control signals, operand values (`regA`, `regB`) and `extend_immediate` each cycle and presents them to the execute stage. It inserts a bubble and raises `stallD` when a load in execute feeds the instruction in decode, squashes on `flushE`, and keeps a saturating bubble counter for performance debug.

## Interface
- `BUBBLE_CNT_W`, 16: width of the saturating bubble counter.
- `clock`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `validD`  in  1  decode slot holds a real instruction.
- `RegWriteD`, `MemtoRegD`, `MemWriteD`, `BranchD`, `RegDstD`, `JumpD`  in  1 each  decoded control from `control_unit`.
- `ALUControlD`  in  4  ALU operation code.
- `regA`, `regB`  in  32  ALU operands, already muxed by `control_unit`.
- `extend_immediate`  in  32  extended immediate.
- `RsD`, `RtD`, `RdD`  in  5  register fields of the decode instruction.
- `PCPlus4D`  in  32  PC+4 of the decode instruction.
- `flushE`  in  1  squash: the next E contents become a bubble.
- `RegWriteE`, `MemtoRegE`, `MemWriteE`, `BranchE`, `RegDstE`, `JumpE`  out  1 each  registered control.
- `ALUControlE`  out  4; `SrcAE`, `SrcBE`, `ImmE`, `PCPlus4E`  out  32 each; `RsE`, `RtE`, `RdE`  out  5 each; `validE`  out  1.
- `stallD`  out  1  combinational; holds the fetch and decode registers.
- `bubble_count`  out  `BUBBLE_CNT_W`  bubbles inserted since reset.

## Operation
- Load-use hazard: `hazard = validE & MemtoRegE & (RtE != 0) & validD & ((RtE == RsD) | (RtE == RtD))`. `stallD = hazard`.
- Next-state priority, highest first:
  - `reset`: all E outputs are 0, `validE = 0`, `bubble_count = 0`.
  - `flushE`: bubble. All E control signals are 0 and `validE = 0`. Data fields are don't-care and are driven to 0.
  - `hazard`: bubble, same as for `flushE`.
  - Otherwise: load every D input into its E counterpart; `validE = validD`.
- A bubble never writes a register or memory, because its control bits are all zero.
- `bubble_count`:
  - Increments by 1 on any edge where `validD = 1` and a bubble is loaded because of `flushE` or `hazard`.
  - Holds at all-ones and does not wrap.
  - A bubble loaded because `validD = 0` is not counted.
- When `flushE` and `hazard` are both active in the same cycle:
  - One bubble is loaded and one count is added.
  - `stallD` stays 1, so decode retries next cycle, when the E stage no longer holds the load.
- Stall lasts exactly one cycle per load-use pair. The load leaves E on the next edge, which deasserts `hazard`.
- Register 0 never creates a hazard.

## Timing
- Latency: D inputs reach E outputs 1 cycle later, on the rising edge.
- `stallD` is combinational from the current E registers and D fields, with zero latency. It must settle before the fetch and decode enables are sampled.
- Reset: every output is 0 on the first edge with `reset = 1`. This includes `stallD`, because `validE = 0`.
- Reset mid-stall: reset wins, E is cleared, and no count is added.
- Back-to-back loads, each dependent on the previous one: each pair yields exactly one bubble.

## Structure
- Shared package `mips_pkg` holds:
  - opcode and funct constants (`OP_LW = 6'b100011`, `OP_SW`, `OP_BEQ`, `OP_BNE`, `OP_J`, `OP_JAL`, `FN_JR`);
  - ALU control constants (`ALU_ADD = 4'b0010`, `ALU_AND = 4'b0100`, `ALU_OR = 4'b0101`, `ALU_XOR = 4'b0110`, `ALU_NOR = 4'b0111`, `ALU_SLT = 4'b1011`, `ALU_SRA = 4'b1100`, `ALU_SRL = 4'b1101`, `ALU_SLL = 4'b1110`);
  - a packed `ctrl_t` bundle of the seven control fields.
- One sub-module, `load_use_detector`, is purely combinational. It takes `validE`, `MemtoRegE`, `RtE`, `validD`, `RsD` and `RtD`, and produces `hazard`.

## Test plan
- Reset: hold `reset` for 2 cycles with random D inputs. Every E output, `stallD` and `bubble_count` must read 0.
- Pass-through: `validD = 1`, `ALUControlD = 4'b0010`, `regA = 5`, `regB = 7`, `RdD = 3`, `RegWriteD = 1`. One cycle later `SrcAE = 5`, `SrcBE = 7`, `RdE = 3`, `RegWriteE = 1` and `validE = 1`.
- Load-use: `lw $8` is in E, and D has `add` with `RsD = 8`. `stallD = 1` in the same cycle. Next cycle `validE = 0`, `RegWriteE = 0` and `bubble_count = 1`. Then `stallD = 0` and the `add` enters E.
- `$0` load: `lw` with `RtE = 0` and `RsD = 0`. `stallD = 0` and no bubble is inserted.
- `flushE` together with a hazard: one bubble, `bubble_count` rises by exactly 1, and `stallD` stays high during the flush cycle.
- Saturation: preload the counter to `16'hFFFE` through repeated flushes, then apply 3 more flushes with `validD = 1`. The counter reads `16'hFFFF` and stays there.
